// File: rtl/gear_pkg.sv
// gear_pkg: shared constants and FSM state type for GeAr adder support logic.
//   GEAR_N  total adder width
//   GEAR_R  result bits produced per sub-adder
//   GEAR_P  carry-prediction bits per sub-adder
//   GEAR_L  sub-adder length (R + P)
package gear_pkg;

    localparam int GEAR_N = 8;
    localparam int GEAR_R = 2;
    localparam int GEAR_P = 4;
    localparam int GEAR_L = GEAR_R + GEAR_P;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DETECT  = 2'd1,
        ST_CORRECT = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/gear_err_detect.sv
// gear_err_detect: combinational carry-prediction error detector for the
// second sub-adder of a GeAr adder.
//   i_a, i_b  lower L = R+P operand bits (the span of the first sub-adder)
//   o_err     1 when the second sub-adder misses a carry into bit L
// The second sub-adder starts at bit R with carry-in 0. It is wrong exactly
// when bits [R-1:0] generate a carry and every bit in [L-1:R] propagates it.
module gear_err_detect
    import gear_pkg::*;
#(
    parameter int R = GEAR_R,
    parameter int P = GEAR_P
) (
    input  logic [R+P-1:0] i_a,
    input  logic [R+P-1:0] i_b,
    output logic           o_err
);

    localparam int L = R + P;

    logic [R:0] w_lo_sum;
    logic       w_c2;
    logic       w_p;

    assign w_lo_sum = {1'b0, i_a[R-1:0]} + {1'b0, i_b[R-1:0]};
    assign w_c2     = w_lo_sum[R];
    assign w_p      = &(i_a[L-1:R] ^ i_b[L-1:R]);
    assign o_err    = w_c2 & w_p;

endmodule

// File: rtl/gear_n8_r2_p4_edc.sv
// gear_n8_r2_p4_edc: error detection/correction stage behind the 8-bit
// GeAr (N=8, R=2, P=4) approximate adder.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand + approximate-sum input handshake
//   in1, in2, approx_res operands and upstream approximate sum
//   out_valid/out_ready  result handshake
//   res                  final sum (exact when corrected)
//   err_flag, corrected  per-beat error / correction indication
//   clr_count            synchronous clear of err_count
//   err_count            saturating count of detected errors
module gear_n8_r2_p4_edc
    import gear_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in1,
    input  logic [7:0]       in2,
    input  logic [8:0]       approx_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       res,
    output logic             err_flag,
    output logic             corrected,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [GEAR_N-GEAR_L:0] HI_ONE  = 1;
    localparam logic [CNT_W-1:0]       CNT_ONE = 1;

    state_t              r_state;
    state_t              w_next;
    logic [GEAR_L-1:0]   r_a;
    logic [GEAR_L-1:0]   r_b;
    logic [GEAR_N:0]     r_approx;
    logic [GEAR_N:0]     r_res;
    logic                r_err;
    logic                r_corr;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_err;
    logic                w_unused;

    // Operand bits above the first sub-adder never influence the carry error.
    assign w_unused = ^{in1[GEAR_N-1:GEAR_L], in2[GEAR_N-1:GEAR_L]};

    gear_err_detect #(
        .R (GEAR_R),
        .P (GEAR_P)
    ) u_detect (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_err (w_err)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid) w_next = ST_DETECT;
            ST_DETECT:  w_next = (w_err && CORRECT_EN) ? ST_CORRECT : ST_OUT;
            ST_CORRECT: w_next = ST_OUT;
            ST_OUT:     if (out_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_approx <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_corr   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= in1[GEAR_L-1:0];
                        r_b      <= in2[GEAR_L-1:0];
                        r_approx <= approx_res;
                    end
                end
                ST_DETECT: begin
                    r_res  <= r_approx;
                    r_err  <= w_err;
                    r_corr <= 1'b0;
                end
                ST_CORRECT: begin
                    // Only the missed carry into bit L is wrong; the exact
                    // sum never exceeds 0x1FE so the upper field cannot wrap.
                    r_res[GEAR_N:GEAR_L] <= r_approx[GEAR_N:GEAR_L] + HI_ONE;
                    r_corr               <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            r_cnt <= '0;
        end else if (r_state == ST_DETECT && w_err && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_OUT);
    assign res       = r_res;
    assign err_flag  = r_err;
    assign corrected = r_corr;
    assign err_count = r_cnt;

endmodule
